// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU issue stage.
//   - opcode encodings (OP_ADD..OP_EQU)
//   - flag bit positions inside the 4-bit flags word {C, V, Z, CMP}
//   - FSM state encodings for the execute stage
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MAX = 3'b110;
  localparam logic [2:0] OP_EQU = 3'b111;

  localparam int unsigned FLG_C   = 3;
  localparam int unsigned FLG_V   = 2;
  localparam int unsigned FLG_Z   = 1;
  localparam int unsigned FLG_CMP = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
//   i_op     opcode (see alu_pkg)
//   i_a/i_b  unsigned operands
//   o_result WIDTH-bit truncated result
//   o_flags  {carry, overflow, zero, cmp}
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;

  assign sum  = {1'b0, i_a} + {1'b0, i_b};
  assign diff = i_a - i_b;

  always_comb begin
    o_result = '0;
    o_flags  = '0;
    unique case (i_op)
      OP_ADD: begin
        o_result       = sum[WIDTH-1:0];
        o_flags[FLG_C] = sum[WIDTH];
        // Same-sign operands producing a differently-signed result.
        o_flags[FLG_V] = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                         (sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        o_result       = diff;
        o_flags[FLG_C] = i_a < i_b;
        // Opposite-sign operands where the result sign differs from A.
        o_flags[FLG_V] = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                         (diff[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_NOT: o_result = ~i_a;
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_MAX: begin
        o_result         = (i_a > i_b) ? i_a : i_b;
        o_flags[FLG_CMP] = i_a > i_b;
      end
      OP_EQU: begin
        o_result         = i_a;
        o_flags[FLG_CMP] = i_a == i_b;
      end
      default: o_result = '0;
    endcase
    o_flags[FLG_Z] = (o_result == '0);
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: registered issue/result stage around alu_core.
//   i_clk, i_rst          clock, async active-high reset
//   i_valid/o_ready       operation handshake (i_op, i_a, i_b)
//   o_valid/i_ready       result handshake (o_result, o_flags from FIFO head)
//   o_busy                execute register occupied
//   o_count               number of results popped, wraps at 8 bits
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags,
  output logic             o_busy,
  output logic [7:0]       o_count
);

  localparam int unsigned EW = WIDTH + 4;

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [EW-1:0]    mem_d [FIFO_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [7:0]       count_q, count_d;

  logic [WIDTH-1:0] core_result;
  logic [3:0]       core_flags;
  logic             pop, push, push_ok, accept;
  logic [EW-1:0]    head;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_op     (op_q),
    .i_a      (a_q),
    .i_b      (b_q),
    .o_result (core_result),
    .o_flags  (core_flags)
  );

  assign pop     = (cnt_q != 2'd0) && i_ready;
  // A full FIFO still takes a push when its head leaves on the same edge.
  assign push_ok = (cnt_q != 2'd2) || pop;
  assign push    = (state_q != ST_IDLE) && push_ok;
  assign o_ready = (state_q == ST_IDLE) || ((state_q == ST_EXEC) && push_ok);
  assign accept  = i_valid && o_ready;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    count_d  = count_q;

    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_EXEC;
      ST_EXEC:  state_d = push ? (accept ? ST_EXEC : ST_IDLE) : ST_STALL;
      ST_STALL: if (push) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (accept) begin
      op_d = i_op;
      a_d  = i_a;
      b_d  = i_b;
    end

    // When full, wr_ptr equals rd_ptr: the new entry overwrites the slot
    // being popped on this same edge and becomes the tail.
    if (push) begin
      mem_d[wr_ptr_q] = {core_result, core_flags};
      wr_ptr_d        = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      count_d  = count_q + 8'd1;
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign o_valid  = (cnt_q != 2'd0);
  // Outputs read as zero whenever nothing is buffered.
  assign o_result = o_valid ? head[EW-1:4] : '0;
  assign o_flags  = o_valid ? head[3:0] : '0;
  assign o_busy   = (state_q != ST_IDLE);
  assign o_count  = count_q;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in, ready_out, valid_out, ready_in, busy;
  logic [2:0] op;
  logic [3:0] a, b, result, flags;
  logic [7:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_pops   = 0;
  int last_pop = 0;
  int prev_pop = 0;
  logic [7:0] expq [$];

  alu_issue #(.WIDTH(4), .FIFO_DEPTH(2)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (valid_in),
    .o_ready  (ready_out),
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .o_valid  (valid_out),
    .i_ready  (ready_in),
    .o_result (result),
    .o_flags  (flags),
    .o_busy   (busy),
    .o_count  (count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: every popped result must match the next hand-written entry.
  always @(negedge clk) begin
    if (!rst && valid_out && ready_in) begin
      if (expq.size() == 0) begin
        check("unexpected_pop", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = expq.pop_front();
        check("pop_result", {28'd0, result}, {28'd0, e[7:4]});
        check("pop_flags",  {28'd0, flags},  {28'd0, e[3:0]});
      end
      n_pops++;
      prev_pop = last_pop;
      last_pop = cyc;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                       output int acc_cyc);
    logic acc;
    op = o; a = x; b = y; valid_in = 1'b1;
    acc = 1'b0;
    acc_cyc = -1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = ready_out;
      if (acc) acc_cyc = cyc;
      @(posedge clk);
      #1;
    end
    if (!acc) check("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && expq.size() != 0; i++) @(negedge clk);
    check("drain_empty", expq.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  int c0, c1;

  initial begin
    rst = 1'b1; valid_in = 1'b0; ready_in = 1'b0; op = '0; a = '0; b = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", valid_out, 0);
    check("rst_busy",  busy, 0);
    check("rst_count", count, 0);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", ready_out, 1);

    // ADD 9+8 -> 1, C=1 V=1: latency and pop count
    ready_in = 1'b1;
    @(posedge clk); #1;
    expq.push_back({4'd1, 4'b1100});
    op = OP_ADD; a = 4'd9; b = 4'd8; valid_in = 1'b1;
    @(negedge clk);
    check("add_ready", ready_out, 1);
    @(posedge clk); #1 valid_in = 1'b0;
    @(negedge clk);
    check("add_lat_valid0", valid_out, 0);
    check("add_lat_busy1", busy, 1);
    @(negedge clk);
    check("add_lat_valid1", valid_out, 1);
    check("add_result", result, 4'd1);
    check("add_flags", flags, 4'b1100);
    check("add_idle", busy, 0);
    @(negedge clk);
    check("count_after_add", count, 8'd1);
    @(posedge clk); #1;

    // SUB 3-3 then MAX 5,12 back-to-back
    expq.push_back({4'd0, 4'b0010});
    expq.push_back({4'd12, 4'b0000});
    issue(OP_SUB, 4'd3, 4'd3, c0);
    issue(OP_MAX, 4'd5, 4'd12, c1);
    valid_in = 1'b0;
    check("b2b_accept_gap", c1 - c0, 1);
    wait_drain();
    check("b2b_pop_gap", last_pop - prev_pop, 1);
    check("count_after_b2b", count, 8'd3);

    // Back-pressure: fill FIFO, third op stalls, fourth waits
    ready_in = 1'b0;
    expq.push_back({4'd3, 4'b0000});   // ADD 1+2
    expq.push_back({4'd6, 4'b0000});   // XOR 5^3
    expq.push_back({4'd9, 4'b0000});   // OR 8|1
    expq.push_back({4'd8, 4'b0000});   // AND C&A
    issue(OP_ADD, 4'd1, 4'd2, c0);
    issue(OP_XOR, 4'd5, 4'd3, c0);
    issue(OP_OR,  4'd8, 4'd1, c0);
    op = OP_AND; a = 4'hC; b = 4'hA; valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready0", ready_out, 0);
      check("stall_busy", busy, 1);
      check("stall_head_stable", result, 4'd3);
    end
    @(posedge clk); #1 ready_in = 1'b1;
    issue(OP_AND, 4'hC, 4'hA, c0);
    valid_in = 1'b0;
    wait_drain();
    check("count_after_stall", count, 8'd7);

    // NOT F -> 0 Z; EQU 6,6 -> 6 cmp
    expq.push_back({4'd0, 4'b0010});
    expq.push_back({4'd6, 4'b0001});
    issue(OP_NOT, 4'hF, 4'd0, c0);
    issue(OP_EQU, 4'd6, 4'd6, c0);
    valid_in = 1'b0;
    wait_drain();

    // Reset with FIFO full and an op in execute
    ready_in = 1'b0;
    issue(OP_ADD, 4'd1, 4'd1, c0);
    issue(OP_ADD, 4'd2, 4'd2, c0);
    issue(OP_ADD, 4'd3, 4'd3, c0);
    valid_in = 1'b0;
    check("pre_rst_busy", busy, 1);
    check("pre_rst_valid", valid_out, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", count, 0);
    expq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", valid_out, 0);
    end
    @(posedge clk); #1;

    // o_count wrap
    for (int i = 0; i < 255; i++) begin
      logic [3:0] v;
      v = i[3:0];
      expq.push_back({v, 2'b00, (v == 4'd0), 1'b1});
      issue(OP_EQU, v, v, c0);
    end
    valid_in = 1'b0;
    wait_drain();
    check("count_255", count, 8'd255);
    expq.push_back({4'd7, 4'b0001});
    issue(OP_EQU, 4'd7, 4'd7, c0);
    valid_in = 1'b0;
    wait_drain();
    check("count_wrap", count, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
